// File: rtl/irq_source_unit_pkg.sv
// Purpose: shared types and constants for the interrupt source unit.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package irq_source_unit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Register offsets within the 8-word window
    localparam logic [2:0] IRQ_CTRL    = 3'd0;
    localparam logic [2:0] IRQ_IER     = 3'd1;
    localparam logic [2:0] IRQ_IFR     = 3'd2;
    localparam logic [2:0] IRQ_TRELOAD = 3'd3;
    localparam logic [2:0] IRQ_TCNT    = 3'd4;
    localparam logic [2:0] IRQ_VBASE   = 3'd5;

    // CTRL bit positions
    localparam int CTRL_TEN = 0;
    localparam int CTRL_GIE = 1;

    // Index of the lowest set bit; bit 0 wins. Returns 0 when v is empty,
    // callers only use the result when v is non-zero.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Purpose: 2-flop synchroniser plus rising-edge detector for one async level line.
// Latency: rise pulses for one cycle, 2 clk edges after async_in goes high.
// Backpressure: none; one pulse per low-to-high transition of the level.
// Ports: clk, rst (async active-low), async_in (raw level), rise (1-cycle pulse).
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/irq_source_unit.sv
// Purpose: memory-mapped interrupt sources (timer + external), IER/IFR, priority and req/ack/done handshake.
// Latency: rdata 1 cycle after address; src_in rise to IFR 3 edges; pending to irq_req 1 edge.
// Backpressure: irq_req/irq_vec hold until irq_ack or abort; no nesting until irq_done.
// Ports: clk, rst (async active-low); addr/wdata/we/rdata CPU bus; src_in external lines
//        (indexed N_SRC-1..1 so bit i maps to IFR[i]); irq_req/irq_vec/irq_ack/irq_done/in_service.
module irq_source_unit
    import irq_source_unit_pkg::*;
#(
    parameter int          N_SRC     = 4,
    parameter logic [15:0] BASE_ADDR = 16'h0400
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      addr,
    input  logic [15:0]      wdata,
    input  logic             we,
    output logic [15:0]      rdata,
    input  logic [N_SRC-1:1] src_in,
    output logic             irq_req,
    output logic [15:0]      irq_vec,
    input  logic             irq_ack,
    input  logic             irq_done,
    output logic             in_service
);

    logic             hit;
    logic [2:0]       off;
    logic             wr_en;

    logic [1:0]       ctrl;
    logic [N_SRC-1:0] ier;
    logic [N_SRC-1:0] ifr;
    logic [15:0]      treload;
    logic [15:0]      tcnt;
    logic [15:0]      vbase;

    logic             timer_run;
    logic             timer_hit;
    logic [N_SRC-1:1] ext_rise;
    logic [N_SRC-1:0] hw_set;
    logic [N_SRC-1:0] sw_clr;
    logic [N_SRC-1:0] ack_clr;
    logic [15:0]      pend;
    logic [3:0]       sel_idx;
    logic [15:0]      rd_mux;

    irq_state_t       state;
    logic [3:0]       idx_q;

    assign hit   = (addr[15:3] == BASE_ADDR[15:3]);
    assign off   = addr[2:0];
    assign wr_en = we & hit;

    for (genvar g = 1; g < N_SRC; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk      (clk),
            .rst      (rst),
            .async_in (src_in[g]),
            .rise     (ext_rise[g])
        );
    end

    // Timer only runs with a non-zero reload, so TRELOAD=0 parks it.
    assign timer_run = ctrl[CTRL_TEN] && (treload != 16'd0);
    assign timer_hit = timer_run && (tcnt == 16'd0);
    assign hw_set    = {ext_rise, timer_hit};

    always_comb begin
        pend            = '0;
        pend[N_SRC-1:0] = ifr & ier;
    end
    assign sel_idx = lowest_set(pend);

    always_comb begin
        sw_clr  = '0;
        ack_clr = '0;
        if (wr_en && off == IRQ_IFR) sw_clr = wdata[N_SRC-1:0];
        if (state == REQ && irq_ack) ack_clr[idx_q] = 1'b1;
    end

    always_comb begin
        rd_mux = '0;
        case (off)
            IRQ_CTRL:    rd_mux[1:0]       = ctrl;
            IRQ_IER:     rd_mux[N_SRC-1:0] = ier;
            IRQ_IFR:     rd_mux[N_SRC-1:0] = ifr;
            IRQ_TRELOAD: rd_mux            = treload;
            IRQ_TCNT:    rd_mux            = tcnt;
            IRQ_VBASE:   rd_mux            = vbase;
            default:     rd_mux            = '0;
        endcase
    end

    // Registers; rdata samples the old contents so a same-cycle write is not visible yet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl    <= '0;
            ier     <= '0;
            ifr     <= '0;
            treload <= '0;
            tcnt    <= '0;
            vbase   <= '0;
            rdata   <= '0;
        end else begin
            rdata <= hit ? rd_mux : 16'd0;
            if (wr_en) begin
                case (off)
                    IRQ_CTRL:    ctrl    <= wdata[1:0];
                    IRQ_IER:     ier     <= wdata[N_SRC-1:0];
                    IRQ_TRELOAD: treload <= wdata;
                    IRQ_VBASE:   vbase   <= wdata;
                    default:     ;
                endcase
            end
            // Hardware sets are OR-ed last so they win over both clears.
            ifr <= (ifr & ~sw_clr & ~ack_clr) | hw_set;
            if (wr_en && off == IRQ_TRELOAD) begin
                tcnt <= wdata;
            end else if (timer_run) begin
                tcnt <= timer_hit ? treload : tcnt - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx_q      <= '0;
            irq_req    <= 1'b0;
            irq_vec    <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl[CTRL_GIE] && pend != 16'd0) begin
                        state   <= REQ;
                        idx_q   <= sel_idx;
                        irq_vec <= vbase + {12'd0, sel_idx};
                        irq_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state      <= SERVICE;
                        irq_req    <= 1'b0;
                        in_service <= 1'b1;
                    end else if (!ctrl[CTRL_GIE] || !pend[idx_q]) begin
                        // Request withdrawn before the controller took it
                        state   <= IDLE;
                        irq_req <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (irq_done) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    irq_req    <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_source_unit.sv
module tb_irq_source_unit;
    import irq_source_unit_pkg::*;

    localparam logic [15:0] BASE = 16'h0400;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        we = 1'b0;
    logic [15:0] rdata;
    logic [3:1]  src_in = '0;
    logic        irq_req;
    logic [15:0] irq_vec;
    logic        irq_ack = 1'b0;
    logic        irq_done = 1'b0;
    logic        in_service;

    int total = 0;
    int bad   = 0;

    irq_source_unit #(.N_SRC(4), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .we         (we),
        .rdata      (rdata),
        .src_in     (src_in),
        .irq_req    (irq_req),
        .irq_vec    (irq_vec),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] off, input logic [15:0] d);
        addr  = BASE + {13'd0, off};
        wdata = d;
        we    = 1'b1;
        tick(1);
        we    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] off, output logic [15:0] d);
        addr = BASE + {13'd0, off};
        we   = 1'b0;
        tick(1);
        d = rdata;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1;
        tick(1);
        irq_done = 1'b0;
    endtask

    // Waits a bounded number of cycles for irq_req; a timeout shows up as a failed check.
    task automatic wait_req(input string tag);
        for (int i = 0; i < 12; i++) begin
            if (irq_req) break;
            tick(1);
        end
        chk(tag, {31'd0, irq_req}, 32'd1);
    endtask

    initial begin
        logic [15:0] d;
        int n;

        // Reset state
        tick(2);
        chk("rst_req", {31'd0, irq_req}, 32'd0);
        chk("rst_vec", {16'd0, irq_vec}, 32'd0);
        chk("rst_insvc", {31'd0, in_service}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        rst = 1'b1;
        tick(1);

        // Bus behaviour
        wr(3'd7, 16'hBEEF);
        rd(3'd7, d);
        chk("off7_read", {16'd0, d}, 32'h0);
        addr = BASE + 16'd8;
        tick(1);
        chk("out_of_window", {16'd0, rdata}, 32'h0);
        wr(IRQ_IER, 16'h000F);
        rd(IRQ_IER, d);
        chk("ier_readback", {16'd0, d}, 32'h000F);
        wr(IRQ_IER, 16'h0000);
        chk("read_pre_write", {16'd0, rdata}, 32'h000F);
        rd(IRQ_IER, d);
        chk("ier_cleared", {16'd0, d}, 32'h0);

        // Timer: reload 3 gives a flag every 4 cycles
        wr(IRQ_VBASE, 16'h0200);
        wr(IRQ_TRELOAD, 16'd3);
        wr(IRQ_IER, 16'h0001);
        wr(IRQ_CTRL, 16'h0001);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            rd(IRQ_IFR, d);
            n++;
            if (d[0]) break;
        end
        chk("timer_first_flag", n, 5);
        wr(IRQ_IFR, 16'h0001);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            rd(IRQ_IFR, d);
            n++;
            if (d[0]) break;
        end
        chk("timer_period", n, 3);

        // Freeze timer, enable GIE: request for source 0
        wr(IRQ_CTRL, 16'h0002);
        tick(1);
        chk("timer_req", {31'd0, irq_req}, 32'd1);
        chk("timer_vec", {16'd0, irq_vec}, 32'h0200);
        rd(IRQ_TCNT, d);
        chk("tcnt_frozen", {16'd0, d}, 32'd1);
        pulse_ack();
        chk("timer_ack_insvc", {31'd0, in_service}, 32'd1);
        chk("timer_ack_req", {31'd0, irq_req}, 32'd0);
        rd(IRQ_IFR, d);
        chk("timer_ack_clr", {16'd0, d}, 32'h0);
        pulse_done();
        chk("timer_done", {31'd0, in_service}, 32'd0);
        pulse_ack();
        chk("stray_ack_insvc", {31'd0, in_service}, 32'd0);
        chk("stray_ack_req", {31'd0, irq_req}, 32'd0);

        // Priority between two external sources
        wr(IRQ_VBASE, 16'h0100);
        wr(IRQ_IER, 16'h0006);
        src_in[1] = 1'b1;
        src_in[2] = 1'b1;
        wait_req("prio_req1");
        chk("prio_vec1", {16'd0, irq_vec}, 32'h0101);
        rd(IRQ_IFR, d);
        chk("prio_ifr_both", {16'd0, d}, 32'h0006);
        pulse_ack();
        rd(IRQ_IFR, d);
        chk("prio_ifr_after_ack", {16'd0, d}, 32'h0004);
        pulse_done();
        wait_req("prio_req2");
        chk("prio_vec2", {16'd0, irq_vec}, 32'h0102);
        pulse_ack();
        pulse_done();
        tick(5);
        rd(IRQ_IFR, d);
        chk("level_once", {16'd0, d}, 32'h0);
        chk("level_no_req", {31'd0, irq_req}, 32'd0);

        // Handshake abort by clearing GIE
        src_in[1] = 1'b0;
        tick(4);
        src_in[1] = 1'b1;
        wait_req("abort_req");
        chk("abort_vec", {16'd0, irq_vec}, 32'h0101);
        wr(IRQ_CTRL, 16'h0000);
        chk("abort_req_hold", {31'd0, irq_req}, 32'd1);
        tick(1);
        chk("abort_req_drop", {31'd0, irq_req}, 32'd0);
        rd(IRQ_IFR, d);
        chk("abort_ifr_kept", {16'd0, d}, 32'h0002);

        // Hardware set beats W1C in the same cycle
        src_in[1] = 1'b0;
        tick(4);
        wr(IRQ_IFR, 16'h0002);
        rd(IRQ_IFR, d);
        chk("w1c_clear", {16'd0, d}, 32'h0);
        src_in[1] = 1'b1;
        tick(2);
        wr(IRQ_IFR, 16'h0002);
        rd(IRQ_IFR, d);
        chk("set_beats_clr", {16'd0, d}, 32'h0002);

        // Reset in the middle of SERVICE
        wr(IRQ_CTRL, 16'h0002);
        wait_req("svc_req");
        pulse_ack();
        chk("svc_insvc", {31'd0, in_service}, 32'd1);
        rst = 1'b0;
        src_in = '0;
        #2;
        chk("midrst_req", {31'd0, irq_req}, 32'd0);
        chk("midrst_insvc", {31'd0, in_service}, 32'd0);
        chk("midrst_vec", {16'd0, irq_vec}, 32'h0);
        chk("midrst_rdata", {16'd0, rdata}, 32'h0);
        tick(2);
        rst = 1'b1;
        tick(1);
        rd(IRQ_CTRL, d);
        chk("post_ctrl", {16'd0, d}, 32'h0);
        rd(IRQ_IER, d);
        chk("post_ier", {16'd0, d}, 32'h0);
        rd(IRQ_IFR, d);
        chk("post_ifr", {16'd0, d}, 32'h0);
        rd(IRQ_VBASE, d);
        chk("post_vbase", {16'd0, d}, 32'h0);
        rd(IRQ_TRELOAD, d);
        chk("post_treload", {16'd0, d}, 32'h0);
        chk("post_insvc", {31'd0, in_service}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
